// File: rtl/taxi_pkg.sv
// Shared taxi-meter definitions: FSM state encodings and default timing constants.
// Used by the tick generator and by the fare and display blocks.
package taxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } tick_state_t;

  localparam logic [31:0] CLK_HZ      = 32'd50_000_000;
  localparam logic [31:0] SEC_PER_MIN = 32'd60;

endpackage

// File: rtl/tick_stage.sv
// One divider stage of the cascaded tick generator: a modulo-DIV counter that
// advances on inc and emits a registered one-cycle pulse when it wraps.
module tick_stage #(
  parameter logic [31:0] DIV = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_p0;
  logic             tick_p1;
  logic             wrap;

  // Compare at full 32-bit width so non-power-of-two ratios wrap exactly.
  assign wrap = (32'(cnt_p0) == (DIV - 32'd1));

  // p0: counter; p1: wrap pulse, one cycle after the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0  <= '0;
      tick_p1 <= 1'b0;
    end else if (clr) begin
      cnt_p0  <= '0;
      tick_p1 <= 1'b0;
    end else if (inc) begin
      if (wrap) begin
        cnt_p0  <= '0;
        tick_p1 <= 1'b1;
      end else begin
        cnt_p0  <= cnt_p0 + CNT_W'(1);
        tick_p1 <= 1'b0;
      end
    end else begin
      tick_p1 <= 1'b0;
    end
  end

  assign tick = tick_p1;

endmodule

// File: rtl/tick_gen.sv
// Cascaded tick generator with gating FSM and saturating elapsed counter for
// waiting-time billing. Define TICK_GEN_FAST_SIM_EN to shorten stage 0 to FAST_DIV0.
module tick_gen
  import taxi_pkg::*;
#(
  parameter int                   STAGES    = 2,
  parameter logic [32*STAGES-1:0] DIVS      = {SEC_PER_MIN, CLK_HZ},
  parameter int                   EL_W      = 8,
  parameter logic [31:0]          FAST_DIV0 = 32'd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              max,
  input  logic              clr,
  output logic [STAGES-1:0] tick,
  output logic [EL_W-1:0]   elapsed,
  output logic              elapsed_sat,
  output logic [1:0]        state
);

`ifdef TICK_GEN_FAST_SIM_EN
  localparam logic [31:0] DIV0 = FAST_DIV0;
`else
  localparam logic [31:0] DIV0 = DIVS[31:0];
`endif

  // Configuration sanity, caught at elaboration rather than as silent miscounting.
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $fatal(1, "tick_gen: STAGES must be 1..4");
  end
  if (FAST_DIV0 < 32'd2) begin : g_bad_fast
    $fatal(1, "tick_gen: FAST_DIV0 must be >= 2");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_chk
    if (DIVS[32*k +: 32] < 32'd2) begin : g_bad_div
      $fatal(1, "tick_gen: every stage ratio must be >= 2");
    end
  end

  function automatic logic [EL_W-1:0] sat_inc(input logic [EL_W-1:0] v);
    return (v == {EL_W{1'b1}}) ? v : v + EL_W'(1);
  endfunction

  tick_state_t       state_p0;
  logic [EL_W-1:0]   elapsed_p0;
  logic [STAGES-1:0] tick_w;
  logic              run;

  assign run = (state_p0 == ST_RUN);

  // FSM: en gates everything; max parks in HOLD from either IDLE or RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
    end else begin
      case (state_p0)
        ST_IDLE: if (en) state_p0 <= max ? ST_HOLD : ST_RUN;
        ST_RUN: begin
          if (!en)     state_p0 <= ST_IDLE;
          else if (max) state_p0 <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!en)      state_p0 <= ST_IDLE;
          else if (!max) state_p0 <= ST_RUN;
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  // Stage 0 counts RUN cycles; upper stages consume the lower pulse even outside RUN.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [31:0] DIV_K = (k == 0) ? DIV0 : DIVS[32*k +: 32];
    logic inc_k;
    if (k == 0) begin : g_first
      assign inc_k = run;
    end else begin : g_next
      assign inc_k = tick_w[k-1];
    end
    tick_stage #(
      .DIV (DIV_K)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc_k),
      .tick (tick_w[k])
    );
  end

  // p0: elapsed count of top-stage ticks, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elapsed_p0 <= '0;
    end else if (clr) begin
      elapsed_p0 <= '0;
    end else if (tick_w[STAGES-1]) begin
      elapsed_p0 <= sat_inc(elapsed_p0);
    end
  end

  assign tick        = tick_w;
  assign elapsed     = elapsed_p0;
  assign elapsed_sat = (elapsed_p0 == {EL_W{1'b1}});
  assign state       = state_p0;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen (STAGES=2, ratios 10 then 3, EL_W=3): directed steps plus
// random en/max/clr, compared every cycle against a count-based reference model.
module tb_tick_gen;

  localparam int D0     = 10;
  localparam int D1     = 3;
  localparam int EL_MAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       max = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] tick;
  logic [2:0] elapsed;
  logic       elapsed_sat;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: totals since the last clear, not divider state.
  int m_state, m_runs, m_t0n, m_el, m_tick0, m_tick1;

  tick_gen #(
    .STAGES    (2),
    .DIVS      ({32'd3, 32'd10}),
    .EL_W      (3),
    .FAST_DIV0 (32'd10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .max         (max),
    .clr         (clr),
    .tick        (tick),
    .elapsed     (elapsed),
    .elapsed_sat (elapsed_sat),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_runs = 0; m_t0n = 0; m_el = 0; m_tick0 = 0; m_tick1 = 0;
  endtask

  task automatic model_edge(input logic e, input logic m, input logic c);
    int ns, nt0, nt1;
    ns = !e ? 0 : (m ? 2 : 1);
    if (c) begin
      m_runs = 0; m_t0n = 0; m_el = 0; m_tick0 = 0; m_tick1 = 0;
    end else begin
      nt0 = (m_state == 1 && ((m_runs + 1) % D0) == 0) ? 1 : 0;
      nt1 = (m_tick0 == 1 && ((m_t0n + 1) % D1) == 0) ? 1 : 0;
      if (m_state == 1) m_runs++;
      if (m_tick0 == 1) m_t0n++;
      if (m_tick1 == 1 && m_el < EL_MAX) m_el++;
      m_tick0 = nt0;
      m_tick1 = nt1;
    end
    m_state = ns;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"}, 32'(tick), 32'(m_tick1 * 2 + m_tick0));
    chk({tag, ".elapsed"}, 32'(elapsed), 32'(m_el));
    chk({tag, ".sat"}, 32'(elapsed_sat), (m_el == EL_MAX) ? 32'd1 : 32'd0);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
  endtask

  task automatic step(input string tag, input logic e, input logic m, input logic c);
    en = e; max = m; clr = c;
    @(posedge clk);
    model_edge(e, m, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    int first0, first1, gap;
    logic e, m, c;

    // Reset state
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all("rst");
    chk("rst.state0", 32'(state), 32'd0);
    #2 rst = 1'b0;

    // 1: first ticks and periods
    step("t1.enter", 1'b1, 1'b0, 1'b0);
    chk("t1.run", 32'(state), 32'd1);
    first0 = -1; first1 = -1;
    for (int i = 1; i <= 35; i++) begin
      step("t1", 1'b1, 1'b0, 1'b0);
      if (tick[0] && first0 < 0) first0 = i;
      if (tick[1] && first1 < 0) first1 = i;
    end
    chk("t1.first_tick0", 32'(first0), 32'd10);
    chk("t1.first_tick1", 32'(first1), 32'd31);

    // 2: freeze under max, resume without restart
    for (int i = 0; i < 20; i++) step("t2.hold", 1'b1, 1'b1, 1'b0);
    chk("t2.state_hold", 32'(state), 32'd2);
    for (int i = 0; i < 15; i++) step("t2.resume", 1'b1, 1'b0, 1'b0);

    // 3: elapsed saturation
    for (int i = 0; i < 250; i++) step("t3", 1'b1, 1'b0, 1'b0);
    chk("t3.elapsed_max", 32'(elapsed), 32'd7);
    chk("t3.sat", 32'(elapsed_sat), 32'd1);

    // 4: clear mid-count
    step("t4.clr0", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (m_el == 2 && (m_runs % D0) == 6) break;
      step("t4.seek", 1'b1, 1'b0, 1'b0);
    end
    chk("t4.pos", 32'(m_runs % D0), 32'd6);
    step("t4.clr", 1'b1, 1'b0, 1'b1);
    chk("t4.elapsed0", 32'(elapsed), 32'd0);
    gap = -1;
    for (int i = 1; i <= 15; i++) begin
      step("t4.after", 1'b1, 1'b0, 1'b0);
      if (tick[0] && gap < 0) gap = i;
    end
    chk("t4.gap", 32'(gap), 32'd10);

    // 5: asynchronous reset just before a wrap
    for (int i = 0; i < 20; i++) begin
      if ((m_runs % D0) == 9) break;
      step("t5.seek", 1'b1, 1'b0, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    chk("t5.tick", 32'(tick), 32'd0);
    chk("t5.elapsed", 32'(elapsed), 32'd0);
    chk("t5.state", 32'(state), 32'd0);
    chk("t5.sat", 32'(elapsed_sat), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("t5.held");
    #2 rst = 1'b0;

    // 6: IDLE round trip and direct IDLE->HOLD
    step("t6.enter", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("t6.run", 1'b1, 1'b0, 1'b0);
    step("t6.stop", 1'b0, 1'b0, 1'b0);
    chk("t6.idle", 32'(state), 32'd0);
    for (int i = 0; i < 5; i++) step("t6.idle_hold", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step("t6.resume", 1'b1, 1'b0, 1'b0);
    step("t6.stop2", 1'b0, 1'b0, 1'b0);
    step("t6.to_hold", 1'b1, 1'b1, 1'b0);
    chk("t6.hold", 32'(state), 32'd2);
    step("t6.rerun", 1'b1, 1'b0, 1'b0);

    // Random en/max/clr traffic
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 49) == 0);
      step("rand", e, m, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
